traceback_controller: RTL and testbench

- Sequences one traceback pass for the B-PE systolic aligner after scoring completes.
- Drives start_traceback and samples the per-cycle base pairs and finish flag returned by the traceback unit.
- Traceback emits pairs end-to-start, so pairs are pushed into a LIFO.
- The LIFO is drained to the downstream consumer in forward alignment order over a valid/ready stream.

---
 rtl/traceback_controller.sv | 216 +++++++++++++++++++++
 tb/tb_traceback_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traceback_controller.sv
// ---------------------------------------------------------------------------
// traceback_controller: runs one traceback pass, reverses the pairs in a LIFO and streams them out.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module traceback_controller #(
    parameter int B     = 4,
    parameter int L     = 8,
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       align_done,
    input  logic       abort,
    output logic       tb_start,
    input  logic [2:0] tb_out_r,
    input  logic [2:0] tb_out_q,
    input  logic       tb_finish,
    output logic       aln_valid,
    input  logic       aln_ready,
    output logic [2:0] aln_r,
    output logic [2:0] aln_q,
    output logic       aln_last,
    output logic [$clog2(DEPTH):0] aln_len,
    output logic       busy,
    output logic       err_overflow
);

    localparam int         SP_W  = $clog2(DEPTH) + 1;
    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [2:0] SENT  = 3'b111;

    if (B < 1 || DEPTH < 2 * L) begin : g_param_check
        $error("traceback_controller: DEPTH cannot hold a full 2*L alignment");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              tb_start_q, tb_start_d;
    logic              aln_valid_q, aln_valid_d;
    logic [2:0]        aln_r_q, aln_r_d;
    logic [2:0]        aln_q_q, aln_q_d;
    logic              aln_last_q, aln_last_d;
    logic [SP_W-1:0]   aln_len_q, aln_len_d;
    logic              busy_q, busy_d;
    logic              err_overflow_q, err_overflow_d;

    logic [5:0]        lifo_mem [DEPTH];
    logic              push_en;
    logic [IDX_W-1:0]  push_idx;
    logic [5:0]        push_data;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  next_idx;
    logic [5:0]        rd_top;
    logic [5:0]        rd_next;
    logic              pair_valid;

    assign pair_valid = !(tb_out_r == SENT && tb_out_q == SENT);
    assign top_idx    = sp_q[IDX_W-1:0] - IDX_W'(1);
    assign next_idx   = sp_q[IDX_W-1:0] - IDX_W'(2);
    assign rd_top     = lifo_mem[top_idx];
    assign rd_next    = lifo_mem[next_idx];

    always_comb begin
        state_d        = state_q;
        sp_d           = sp_q;
        tb_start_d     = tb_start_q;
        aln_valid_d    = aln_valid_q;
        aln_r_d        = aln_r_q;
        aln_q_d        = aln_q_q;
        aln_last_d     = aln_last_q;
        aln_len_d      = aln_len_q;
        err_overflow_d = err_overflow_q;
        push_en        = 1'b0;
        push_idx       = sp_q[IDX_W-1:0];
        push_data      = {tb_out_r, tb_out_q};

        case (state_q)
            ST_IDLE: begin
                if (align_done) begin
                    state_d        = ST_ARM;
                    tb_start_d     = 1'b1;
                    err_overflow_d = 1'b0;
                    sp_d           = '0;
                    aln_len_d      = '0;
                end
            end

            // The unit answers the first start cycle with a sentinel; nothing to sample yet.
            ST_ARM: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (pair_valid && sp_q == SP_W'(DEPTH)) begin
                    err_overflow_d = 1'b1;
                    tb_start_d     = 1'b0;
                    state_d        = ST_DRAIN;
                    aln_len_d      = SP_W'(DEPTH);
                    aln_valid_d    = 1'b1;
                    {aln_r_d, aln_q_d} = rd_top;
                    aln_last_d     = (sp_q == SP_W'(1));
                end else begin
                    if (pair_valid) begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                    end
                    if (tb_finish) begin
                        tb_start_d  = 1'b0;
                        state_d     = ST_DRAIN;
                        aln_len_d   = sp_d;
                        aln_valid_d = 1'b1;
                        // The first beat is the pair being pushed right now, if any.
                        if (pair_valid) begin
                            {aln_r_d, aln_q_d} = push_data;
                            aln_last_d         = (sp_d == SP_W'(1));
                        end else if (sp_q != '0) begin
                            {aln_r_d, aln_q_d} = rd_top;
                            aln_last_d         = (sp_q == SP_W'(1));
                        end else begin
                            aln_r_d    = SENT;
                            aln_q_d    = SENT;
                            aln_last_d = 1'b1;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                if (aln_valid_q && aln_ready) begin
                    if (sp_q <= SP_W'(1)) begin
                        state_d     = ST_IDLE;
                        sp_d        = '0;
                        aln_valid_d = 1'b0;
                        aln_last_d  = 1'b0;
                        aln_r_d     = 3'b000;
                        aln_q_d     = 3'b000;
                    end else begin
                        sp_d               = sp_q - SP_W'(1);
                        {aln_r_d, aln_q_d} = rd_next;
                        aln_last_d         = (sp_q == SP_W'(2));
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            tb_start_d  = 1'b0;
            aln_valid_d = 1'b0;
            aln_last_d  = 1'b0;
            aln_r_d     = 3'b000;
            aln_q_d     = 3'b000;
            sp_d        = '0;
            push_en     = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            sp_q           <= '0;
            tb_start_q     <= 1'b0;
            aln_valid_q    <= 1'b0;
            aln_r_q        <= 3'b000;
            aln_q_q        <= 3'b000;
            aln_last_q     <= 1'b0;
            aln_len_q      <= '0;
            busy_q         <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sp_q           <= sp_d;
            tb_start_q     <= tb_start_d;
            aln_valid_q    <= aln_valid_d;
            aln_r_q        <= aln_r_d;
            aln_q_q        <= aln_q_d;
            aln_last_q     <= aln_last_d;
            aln_len_q      <= aln_len_d;
            busy_q         <= busy_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            lifo_mem[push_idx] <= push_data;
        end
    end

    assign tb_start     = tb_start_q;
    assign aln_valid    = aln_valid_q;
    assign aln_r        = aln_r_q;
    assign aln_q        = aln_q_q;
    assign aln_last     = aln_last_q;
    assign aln_len      = aln_len_q;
    assign busy         = busy_q;
    assign err_overflow = err_overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_traceback_controller.sv
// ---------------------------------------------------------------------------
// tb_traceback_controller: random and directed traceback passes checked against a queue-based model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_traceback_controller;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       align_done = 1'b0;
    logic       abort = 1'b0;
    logic       tb_start;
    logic [2:0] tb_out_r = 3'b111;
    logic [2:0] tb_out_q = 3'b111;
    logic       tb_finish = 1'b0;
    logic       aln_valid;
    logic       aln_ready = 1'b0;
    logic [2:0] aln_r;
    logic [2:0] aln_q;
    logic       aln_last;
    logic [4:0] aln_len;
    logic       busy;
    logic       err_overflow;

    traceback_controller #(.B(4), .L(8), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .align_done   (align_done),
        .abort        (abort),
        .tb_start     (tb_start),
        .tb_out_r     (tb_out_r),
        .tb_out_q     (tb_out_q),
        .tb_finish    (tb_finish),
        .aln_valid    (aln_valid),
        .aln_ready    (aln_ready),
        .aln_r        (aln_r),
        .aln_q        (aln_q),
        .aln_last     (aln_last),
        .aln_len      (aln_len),
        .busy         (busy),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Traceback unit model: sentinel on the first start cycle, then the emitted list.
    logic [5:0] tb_list [$];
    int         fin_idx = -1;
    bit         rep_fin = 1'b0;
    int         drv_idx = 0;
    logic       drv_prev = 1'b0;

    always @(negedge clk) begin
        if (tb_start) begin
            if (!drv_prev) begin
                tb_out_r  = 3'b111;
                tb_out_q  = 3'b111;
                tb_finish = 1'b0;
                drv_idx   = 0;
            end else if (drv_idx < tb_list.size()) begin
                {tb_out_r, tb_out_q} = tb_list[drv_idx];
                tb_finish = (drv_idx == fin_idx);
                drv_idx++;
            end else begin
                tb_out_r  = 3'b111;
                tb_out_q  = 3'b111;
                tb_finish = 1'b0;
            end
        end else begin
            tb_out_r  = 3'($urandom);
            tb_out_q  = 3'($urandom);
            tb_finish = rep_fin;
        end
        drv_prev = tb_start;
    end

    // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic run_pass(input int ready_mode, input int abort_run, input bit poke);
        logic [5:0] exp_pairs [$];
        logic [6:0] exp_beats [$];
        logic [6:0] beats [$];
        logic [7:0] prev_out;
        int  exp_len, exp_high, high, cyc, ph;
        bit  exp_err, seen_busy, prev_stall, any_valid, len_seen, drain_poked, rdy;

        exp_high = 0;
        exp_err  = 1'b0;
        for (int i = 0; i < tb_list.size(); i++) begin
            if (tb_list[i] != 6'h3f) begin
                if (exp_pairs.size() == DEPTH) begin
                    exp_err  = 1'b1;
                    exp_high = i + 2;
                    break;
                end
                exp_pairs.push_front(tb_list[i]);
            end
            if (i == fin_idx) begin
                exp_high = i + 2;
                break;
            end
        end
        exp_len = exp_pairs.size();
        if (exp_len == 0) begin
            exp_beats.push_back({6'h3f, 1'b1});
        end else begin
            foreach (exp_pairs[i]) exp_beats.push_back({exp_pairs[i], i == exp_len - 1});
        end
        if (abort_run > 0) begin
            exp_beats.delete();
            exp_len  = 0;
            exp_err  = 1'b0;
            exp_high = abort_run + 1;
        end

        @(negedge clk);
        align_done  = 1'b1;
        cyc         = 0;
        ph          = 0;
        high        = 0;
        seen_busy   = 1'b0;
        prev_stall  = 1'b0;
        any_valid   = 1'b0;
        len_seen    = 1'b0;
        drain_poked = 1'b0;
        prev_out    = '0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            align_done = 1'b0;
            abort      = 1'b0;
            if (busy) seen_busy = 1'b1;
            if (seen_busy && !busy) break;
            if (tb_start) begin
                high++;
                if (poke && high == 3) align_done = 1'b1;
                if (abort_run > 0 && high == abort_run + 1) abort = 1'b1;
            end
            if (prev_stall) check_val("hold", {aln_valid, aln_r, aln_q, aln_last}, prev_out);
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (ph % 4 == 0) || (ph % 4 == 3);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            aln_ready = rdy;
            if (aln_valid) begin
                ph++;
                any_valid = 1'b1;
                if (!len_seen) begin
                    check_val("len_drain", aln_len, exp_len);
                    len_seen = 1'b1;
                end
                if (poke && !drain_poked) begin
                    align_done  = 1'b1;
                    drain_poked = 1'b1;
                end
                if (rdy) beats.push_back({aln_r, aln_q, aln_last});
                prev_stall = !rdy;
                prev_out   = {aln_valid, aln_r, aln_q, aln_last};
            end else begin
                prev_stall = 1'b0;
            end
        end
        align_done = 1'b0;
        abort      = 1'b0;
        aln_ready  = 1'b0;
        if (cyc >= 300) check_val("timeout", 1, 0);

        check_val("beat_count", beats.size(), exp_beats.size());
        for (int i = 0; i < beats.size() && i < exp_beats.size(); i++)
            check_val($sformatf("beat%0d", i), beats[i], exp_beats[i]);
        if (abort_run > 0) check_val("abort_valid", any_valid, 0);
        check_val("tb_start_cycles", high, exp_high);
        check_val("len_end", aln_len, exp_len);
        check_val("err_overflow", err_overflow, exp_err);
        check_val("idle_outs", {busy, tb_start, aln_valid}, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_list(input int n);
        tb_list.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 5) == 0) tb_list.push_back(6'h3f);
            else tb_list.push_back({3'($urandom_range(0, 7)), 3'($urandom_range(0, 4))});
        end
        fin_idx = n - 1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_val("reset", {tb_start, aln_valid, aln_last, aln_r, aln_q, aln_len, busy, err_overflow}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Pure diagonal, emitted in reverse order.
        tb_list.delete();
        for (int i = 7; i >= 0; i--) tb_list.push_back({3'(i % 4), 3'(i % 4)});
        fin_idx = 7;
        run_pass(0, 0, 1'b0);

        // Gapped path: R gaps at emitted positions 3 and 7.
        tb_list.delete();
        for (int i = 1; i <= 10; i++)
            tb_list.push_back((i == 3 || i == 7) ? {3'b100, 3'($urandom_range(0, 3))}
                                                 : {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))});
        fin_idx = 9;
        run_pass(0, 0, 1'b0);

        // Backpressure.
        rand_list(12);
        run_pass(1, 0, 1'b0);

        // Overflow, then a normal pass that must clear the error.
        tb_list.delete();
        for (int i = 0; i < 20; i++) tb_list.push_back({3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))});
        fin_idx = -1;
        run_pass(1, 0, 1'b0);
        rand_list(5);
        run_pass(0, 0, 1'b0);

        // Empty alignment: only sentinels before finish.
        tb_list.delete();
        repeat (3) tb_list.push_back(6'h3f);
        fin_idx = 2;
        run_pass(2, 0, 1'b0);

        // Abort in the 4th RUN cycle.
        rand_list(10);
        run_pass(0, 4, 1'b0);

        // Ignored align_done in RUN/DRAIN plus repeated finish.
        rep_fin = 1'b1;
        rand_list(9);
        run_pass(1, 0, 1'b1);
        rep_fin = 1'b0;

        // Random passes.
        for (int k = 0; k < 10; k++) begin
            rand_list($urandom_range(1, 22));
            run_pass($urandom_range(0, 2), 0, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of DRAIN.
        tb_list.delete();
        for (int i = 0; i < 6; i++) tb_list.push_back({3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))});
        fin_idx = 5;
        @(negedge clk);
        align_done = 1'b1;
        @(negedge clk);
        align_done = 1'b0;
        aln_ready  = 1'b0;
        begin
            int w;
            w = 0;
            while (!aln_valid && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) check_val("rst_wait", 0, 1);
        end
        #2 rst_n = 1'b0;
        #1 check_val("rst_async", {tb_start, aln_valid, aln_last, aln_r, aln_q, aln_len, busy, err_overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        rand_list(7);
        run_pass(2, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
